// File: rtl/serial_sum_receiver.sv
// serial_sum_receiver: LSB-first bit-serial adder that deserializes A+B into a held,
// handshaked result with unsigned carry, signed overflow and a sticky framing error flag.
module serial_sum_receiver #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_valid,
    input  logic             frame_start,
    input  logic             bit_a,
    input  logic             bit_b,
    input  logic             sum_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout,
    output logic             overflow,
    output logic             sum_valid,
    output logic             busy,
    output logic             frame_err
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [1:0] IDLE = 2'd0, RECV = 2'd1, DONE = 2'd2;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    logic [1:0] state, state_nxt;
    logic [CW-1:0] cnt;
    logic [WIDTH-1:0] base;
    logic carry, first, take, last, err, c_in, s_bit, c_nxt;
    // A frame start is honoured anywhere except a DONE whose result is not being accepted
    always_comb begin
        first = bit_valid && frame_start && (state != DONE || sum_ready);
        take = first || (bit_valid && state == RECV);
        last = take && !first && cnt == LAST;
        err = bit_valid && (state == IDLE ? !frame_start :
                            state == RECV ? frame_start : !(sum_ready && frame_start));
        c_in = first ? 1'b0 : carry;
        s_bit = bit_a ^ bit_b ^ c_in;
        c_nxt = (bit_a & bit_b) | (c_in & (bit_a ^ bit_b));
        base = first ? '0 : sum_out;
        state_nxt = last ? DONE : first ? RECV : (state == DONE && sum_ready) ? IDLE : state;
    end
    assign busy = state == RECV;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            carry <= 1'b0;
            sum_out <= '0;
            cout <= 1'b0;
            overflow <= 1'b0;
            sum_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (err)
                frame_err <= 1'b1;
            if (take) begin
                carry <= c_nxt;
                sum_out <= {s_bit, base[WIDTH-1:1]};
                cnt <= first ? CW'(1) : cnt + CW'(1);
            end
            if (last) begin
                cout <= c_nxt;
                overflow <= c_in ^ c_nxt;
                sum_valid <= 1'b1;
            end else if (state == DONE && sum_ready) begin
                sum_valid <= 1'b0;
            end
        end
    end
endmodule
